// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
// Master-mode SPI sequencer. Generates SCK at a selectable rate, drives slave
// select, and emits one-cycle shift/sample strobes for an external shift
// register. Maintains the transfer-complete (spif) and write-collision (wcol)
// flags.
//
// Optional build macro: SPI_CTRL_IRQ_EN
//   When defined, adds input spie and output irq (irq = spif & spie, registered).
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   spe        SPI enable; dropping it aborts a transfer
//   mstr       master select; transfers start only when high
//   cpol       SCK idle level
//   cpha       clock phase
//   spr[1:0]   half-period select: 1, 2, 4, 8 clk cycles
//   start      one-cycle pulse from a data-register write
//   flag_clr   clears spif and wcol (a same-cycle set wins)
//   spie       interrupt enable        (SPI_CTRL_IRQ_EN only)
//   irq        interrupt request       (SPI_CTRL_IRQ_EN only)
//   sck        serial clock to pad
//   ss_n       slave select, active-low
//   shift_en   one-cycle strobe: advance shifter one bit
//   sample_en  one-cycle strobe: capture MISO
//   busy       high while in LOAD, XFER or DONE
//   spif       transfer-complete flag
//   wcol       write-collision flag
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | sck follows live cpol, ss_n high, waiting for start
// LOAD   | one cycle, ss_n low; first bit presented when cpha=0
// XFER   | 2*DWIDTH sck toggles, one every H cycles
// DONE   | one cycle after the last toggle; sets spif on exit
// -----------------------------------------------------------------------------
module spi_controller #(
  parameter int DWIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spe,
  input  logic       mstr,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [1:0] spr,
  input  logic       start,
  input  logic       flag_clr,
`ifdef SPI_CTRL_IRQ_EN
  input  logic       spie,
  output logic       irq,
`endif
  output logic       sck,
  output logic       ss_n,
  output logic       shift_en,
  output logic       sample_en,
  output logic       busy,
  output logic       spif,
  output logic       wcol
);

  localparam int TW = $clog2(2 * DWIDTH + 1);
  localparam logic [TW-1:0] TGL_TOTAL = TW'(2 * DWIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_cpol;
  logic          r_cpha;
  logic [1:0]    r_spr;
  logic [2:0]    r_div;
  logic [TW-1:0] r_tgl_left;
  logic          r_sck;
  logic          r_ss_n;
  logic          r_shift_en;
  logic          r_sample_en;
  logic          r_busy;
  logic          r_spif;
  logic          r_wcol;

  logic w_tgl_now;
  logic w_leading;
  logic w_last;
  logic w_spif_set;
  logic w_wcol_set;

  // Reload value for the half-period down-counter (H-1).
  function automatic logic [2:0] half_m1(input logic [1:0] s);
    case (s)
      2'b00:   half_m1 = 3'd0;
      2'b01:   half_m1 = 3'd1;
      2'b10:   half_m1 = 3'd3;
      default: half_m1 = 3'd7;
    endcase
  endfunction

  assign w_tgl_now  = (r_div == 3'd0);
  // Toggles remaining counts down from an even total, so an even remainder
  // marks an odd (leading) toggle.
  assign w_leading  = ~r_tgl_left[0];
  assign w_last     = (r_tgl_left == TW'(1));
  // An abort in DONE leaves spif untouched.
  assign w_spif_set = (r_state == S_DONE) && spe;
  assign w_wcol_set = start && r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_spr       <= 2'b00;
      r_div       <= 3'd0;
      r_tgl_left  <= '0;
      r_sck       <= 1'b0;
      r_ss_n      <= 1'b1;
      r_shift_en  <= 1'b0;
      r_sample_en <= 1'b0;
      r_busy      <= 1'b0;
      r_spif      <= 1'b0;
      r_wcol      <= 1'b0;
    end else begin
      r_shift_en  <= 1'b0;
      r_sample_en <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_sck  <= cpol;
          r_ss_n <= 1'b1;
          r_busy <= 1'b0;
          if (start && spe && mstr) begin
            r_state    <= S_LOAD;
            r_cpol     <= cpol;
            r_cpha     <= cpha;
            r_spr      <= spr;
            r_ss_n     <= 1'b0;
            r_busy     <= 1'b1;
            // cpha=0 presents the first bit before the first edge.
            r_shift_en <= ~cpha;
          end
        end

        S_LOAD: begin
          r_state    <= S_XFER;
          r_div      <= half_m1(r_spr);
          r_tgl_left <= TGL_TOTAL;
        end

        S_XFER: begin
          if (w_tgl_now) begin
            r_sck      <= ~r_sck;
            r_div      <= half_m1(r_spr);
            r_tgl_left <= r_tgl_left - TW'(1);
            if (r_cpha) begin
              r_shift_en  <= w_leading;
              r_sample_en <= ~w_leading;
            end else begin
              r_sample_en <= w_leading;
              r_shift_en  <= ~w_leading && ~w_last;
            end
            if (w_last) r_state <= S_DONE;
          end else begin
            r_div <= r_div - 3'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_sck   <= cpol;
          r_ss_n  <= 1'b1;
          r_busy  <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase

      // Disable while active overrides whatever the state logic chose.
      if ((r_state != S_IDLE) && !spe) begin
        r_state     <= S_IDLE;
        r_sck       <= r_cpol;
        r_ss_n      <= 1'b1;
        r_busy      <= 1'b0;
        r_shift_en  <= 1'b0;
        r_sample_en <= 1'b0;
      end

      // Clear first so a same-cycle set wins.
      if (flag_clr) begin
        r_spif <= 1'b0;
        r_wcol <= 1'b0;
      end
      if (w_spif_set) r_spif <= 1'b1;
      if (w_wcol_set) r_wcol <= 1'b1;
    end
  end

`ifdef SPI_CTRL_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= r_spif & spie;
  end

  assign irq = r_irq;
`endif

  assign sck       = r_sck;
  assign ss_n      = r_ss_n;
  assign shift_en  = r_shift_en;
  assign sample_en = r_sample_en;
  assign busy      = r_busy;
  assign spif      = r_spif;
  assign wcol      = r_wcol;

endmodule
